// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Central stall/flush sequencer for a 5-stage RV32I pipeline.
// Each cycle it decides which pipeline registers advance, hold, take a
// bubble or flush. It bases that decision on three things: outstanding
// I/D-cache transactions, data hazards that forwarding cannot cover, and
// ID-stage control-flow redirects. A cache that completes early is
// remembered, so it is not re-requested while the other cache is still busy.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_ex_in_ctrl               control word of the instruction in ID
//   id_ex_out_ctrl              control word of the instruction in EX
//   ex_mem_out_ctrl             control word of the instruction in MEM
//   id_redirect                 ID resolved a taken branch/jal/jalr
//   imem_read, imem_resp        I-cache request / response
//   dmem_read, dmem_write,
//   dmem_resp                   D-cache requests / response
//   load_pc .. load_mem_wb      pipeline register enables
//   flush_if_id, bubble_id_ex   NOP insertion controls
//   imem_req_mask, dmem_req_mask  suppress requests to a cache that already answered
//   stall_count, flush_count    saturating performance counters

package rv32i_types;
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_out  = 3'd0,
      br_en    = 3'd1,
      u_imm    = 3'd2,
      lw       = 3'd3,
      pc_plus4 = 3'd4
   } regfilemux_sel_t;

   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU = 3'b011;

   typedef struct packed {
      rv32i_opcode     opcode;
      logic [2:0]      funct3;
      logic [4:0]      rs1_id;
      logic [4:0]      rs2_id;
      logic [4:0]      rd_id;
      logic            load_regfile;
      regfilemux_sel_t regfile_mux_sel;
   } rv32i_control_word;
endpackage

module pipeline_hazard_controller
   import rv32i_types::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  rv32i_control_word    id_ex_in_ctrl,
   input  rv32i_control_word    id_ex_out_ctrl,
   input  rv32i_control_word    ex_mem_out_ctrl,
   input  logic                 id_redirect,
   input  logic                 imem_read,
   input  logic                 imem_resp,
   input  logic                 dmem_read,
   input  logic                 dmem_write,
   input  logic                 dmem_resp,
   output logic                 load_pc,
   output logic                 load_if_id,
   output logic                 load_id_ex,
   output logic                 load_ex_mem,
   output logic                 load_mem_wb,
   output logic                 flush_if_id,
   output logic                 bubble_id_ex,
   output logic                 imem_req_mask,
   output logic                 dmem_req_mask,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, I_DONE, D_DONE} mem_state_t;

   mem_state_t state_reg, state_next;
   logic       i_pend, d_pend, mem_stall, hz;

   function automatic logic uses_rs1(input rv32i_opcode op);
      return !((op == op_lui) || (op == op_auipc) || (op == op_jal));
   endfunction

   function automatic logic uses_rs2(input rv32i_opcode op);
      return (op == op_reg) || (op == op_br) || (op == op_store);
   endfunction

   function automatic logic writes_reg(input logic [4:0] rs, input logic load_regfile,
                                       input logic [4:0] rd_id);
      return load_regfile && (rd_id != 5'd0) && (rd_id == rs);
   endfunction

   // ---------------- memory stall ----------------
   // A cache whose answer is already latched is no longer pending.
   assign i_pend    = imem_read && (state_reg != I_DONE) && !imem_resp;
   assign d_pend    = (dmem_read || dmem_write) && (state_reg != D_DONE) && !dmem_resp;
   assign mem_stall = i_pend || d_pend;

   // ---------------- data hazard ----------------
   // Instructions resolved in ID (branches, jalr, slt/sltu feeding a compare)
   // need their operands one stage earlier than EX-stage forwarding provides.
   logic       id_resolved, ex_is_load, mem_is_load, ex_value_late;
   logic [4:0] src_id [2];
   logic [1:0] src_used, src_hz;

   assign id_resolved = (id_ex_in_ctrl.opcode == op_br) || (id_ex_in_ctrl.opcode == op_jalr) ||
                        (((id_ex_in_ctrl.opcode == op_reg) || (id_ex_in_ctrl.opcode == op_imm)) &&
                         ((id_ex_in_ctrl.funct3 == FUNCT3_SLT) || (id_ex_in_ctrl.funct3 == FUNCT3_SLTU)));
   assign ex_is_load  = (id_ex_out_ctrl.opcode == op_load);
   assign mem_is_load = (ex_mem_out_ctrl.opcode == op_load);
   // lui and br_en results exist early enough in EX to forward into ID.
   assign ex_value_late = (id_ex_out_ctrl.opcode != op_lui) && (id_ex_out_ctrl.regfile_mux_sel != br_en);

   assign src_id[0]   = id_ex_in_ctrl.rs1_id;
   assign src_id[1]   = id_ex_in_ctrl.rs2_id;
   assign src_used[0] = uses_rs1(id_ex_in_ctrl.opcode);
   assign src_used[1] = uses_rs2(id_ex_in_ctrl.opcode);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic ex_match, mem_match;
         assign ex_match  = writes_reg(src_id[gi], id_ex_out_ctrl.load_regfile, id_ex_out_ctrl.rd_id);
         assign mem_match = writes_reg(src_id[gi], ex_mem_out_ctrl.load_regfile, ex_mem_out_ctrl.rd_id);
         assign src_hz[gi] = src_used[gi] &&
                             ((ex_is_load && ex_match) ||
                              (id_resolved && ((ex_match && ex_value_late) || (mem_match && mem_is_load))));
      end
   endgenerate

   assign hz = |src_hz;

   // ---------------- memory FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_reg <= RUN;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN: begin
            if (imem_resp && d_pend)      state_next = I_DONE;
            else if (dmem_resp && i_pend) state_next = D_DONE;
         end
         I_DONE:  if (!d_pend) state_next = RUN;
         D_DONE:  if (!i_pend) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // ---------------- pipeline control outputs ----------------
   always_comb begin
      load_pc       = 1'b0;
      load_if_id    = 1'b0;
      load_id_ex    = 1'b0;
      load_ex_mem   = 1'b0;
      load_mem_wb   = 1'b0;
      flush_if_id   = 1'b0;
      bubble_id_ex  = 1'b0;
      imem_req_mask = 1'b0;
      dmem_req_mask = 1'b0;
      if (!rst) begin
         imem_req_mask = (state_reg == I_DONE);
         dmem_req_mask = (state_reg == D_DONE);
         if (mem_stall) begin
            // everything frozen; a pending redirect stays in ID and is re-seen later
         end else if (hz) begin
            load_id_ex   = 1'b1;
            bubble_id_ex = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
         end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = id_redirect;
         end
      end
   end

   // ---------------- saturating performance counters ----------------
   // index 0: stalled cycles, index 1: flushes
   logic [1:0]           cnt_inc;
   logic [CNT_WIDTH-1:0] cnt_reg [2];

   assign cnt_inc = {flush_if_id, mem_stall || hz};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst)                                    cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
         end
      end
   endgenerate

   assign stall_count = cnt_reg[0];
   assign flush_count = cnt_reg[1];

   // Control-word fields this block has no use for.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^{id_ex_in_ctrl.rd_id, id_ex_in_ctrl.load_regfile, id_ex_in_ctrl.regfile_mux_sel,
                               id_ex_out_ctrl.funct3, id_ex_out_ctrl.rs1_id, id_ex_out_ctrl.rs2_id,
                               ex_mem_out_ctrl.funct3, ex_mem_out_ctrl.rs1_id, ex_mem_out_ctrl.rs2_id,
                               ex_mem_out_ctrl.regfile_mux_sel};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller: table-driven vectors, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_pipeline_hazard_controller;
   import rv32i_types::*;

   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   rv32i_control_word id_c, ex_c, mem_c;
   logic id_redirect, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
   logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic flush_if_id, bubble_id_ex, imem_req_mask, dmem_req_mask;
   logic [CW-1:0] stall_count, flush_count;

   pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .id_ex_in_ctrl(id_c), .id_ex_out_ctrl(ex_c), .ex_mem_out_ctrl(mem_c),
      .id_redirect(id_redirect),
      .imem_read(imem_read), .imem_resp(imem_resp),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
      .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
      .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
      .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
      .imem_req_mask(imem_req_mask), .dmem_req_mask(dmem_req_mask),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   // held_i / held_d: a cache answer that has been received and is being
   // remembered while the pipeline still waits on the other cache.
   bit held_i, held_d;
   int m_stall, m_flush;

   // values sampled in the last cycle, for hand-written checks
   logic [4:0] got_loads;
   logic got_flush, got_bubble, got_imask, got_dmask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic rv32i_control_word mk(input rv32i_opcode op, input int f3, input int rs1,
                                           input int rs2, input int rd, input bit lrf,
                                           input regfilemux_sel_t sel);
      rv32i_control_word c;
      c.opcode = op; c.funct3 = 3'(f3); c.rs1_id = 5'(rs1); c.rs2_id = 5'(rs2);
      c.rd_id = 5'(rd); c.load_regfile = lrf; c.regfile_mux_sel = sel;
      return c;
   endfunction

   function automatic bit reg_read(input rv32i_control_word c, input int which);
      if (which == 0) return !(c.opcode inside {op_lui, op_auipc, op_jal});
      return c.opcode inside {op_reg, op_br, op_store};
   endfunction

   function automatic bit produces(input rv32i_control_word c, input logic [4:0] r);
      return c.load_regfile && (c.rd_id != 0) && (c.rd_id == r);
   endfunction

   function automatic bit model_hazard();
      bit resolved;
      logic [4:0] r;
      resolved = (id_c.opcode inside {op_br, op_jalr}) ||
                 ((id_c.opcode inside {op_reg, op_imm}) && (id_c.funct3 inside {3'd2, 3'd3}));
      for (int s = 0; s < 2; s++) begin
         r = (s == 0) ? id_c.rs1_id : id_c.rs2_id;
         if (!reg_read(id_c, s)) continue;
         if (ex_c.opcode == op_load && produces(ex_c, r)) return 1;
         if (resolved && produces(ex_c, r) && ex_c.opcode != op_lui && ex_c.regfile_mux_sel != br_en) return 1;
         if (resolved && mem_c.opcode == op_load && produces(mem_c, r)) return 1;
      end
      return 0;
   endfunction

   function automatic bit model_mem_wait();
      bit i_wait, d_wait;
      i_wait = imem_read && !held_i && !imem_resp;
      d_wait = (dmem_read || dmem_write) && !held_d && !dmem_resp;
      return i_wait || d_wait;
   endfunction

   // One clock cycle: check at the falling edge, advance the model at the rising edge.
   task automatic cycle(input string tag);
      bit ms, hzm, nhi, nhd;
      logic [4:0] el;
      logic ef, eb, eim, edm;
      @(negedge clk);
      ms = 0; hzm = 0; el = 5'b0; ef = 0; eb = 0; eim = 0; edm = 0;
      if (!rst) begin
         ms = model_mem_wait();
         hzm = model_hazard();
         eim = held_i; edm = held_d;
         if (ms) el = 5'b0;
         else if (hzm) begin el = 5'b00111; eb = 1; end
         else begin el = 5'b11111; ef = id_redirect; end
      end
      got_loads  = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
      got_flush  = flush_if_id;  got_bubble = bubble_id_ex;
      got_imask  = imem_req_mask; got_dmask = dmem_req_mask;
      chk({tag, ".loads"},  32'(got_loads), 32'(el));
      chk({tag, ".flush"},  32'(got_flush), 32'(ef));
      chk({tag, ".bubble"}, 32'(got_bubble), 32'(eb));
      chk({tag, ".imask"},  32'(got_imask), 32'(eim));
      chk({tag, ".dmask"},  32'(got_dmask), 32'(edm));
      chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
      chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
      $display("[%0t] %s rst=%b redir=%b i=%b/%b d=%b%b/%b loads=%b flush=%b bubble=%b masks=%b%b stall_cnt=%0d flush_cnt=%0d",
               $time, tag, rst, id_redirect, imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
               got_loads, got_flush, got_bubble, got_imask, got_dmask, stall_count, flush_count);
      @(posedge clk);
      if (rst) begin
         held_i = 0; held_d = 0; m_stall = 0; m_flush = 0;
      end else begin
         // an answer stays remembered only while the pipeline is still stalled
         nhi = ms && (held_i || imem_resp) && !held_d;
         nhd = ms && (held_d || dmem_resp) && !held_i;
         held_i = nhi; held_d = nhd;
         if ((ms || hzm) && m_stall < MAXC) m_stall++;
         if (ef && m_flush < MAXC) m_flush++;
      end
      #1;
   endtask

   rv32i_control_word NOP;

   task automatic idle_inputs();
      id_c = NOP; ex_c = NOP; mem_c = NOP;
      id_redirect = 0; imem_read = 0; imem_resp = 0;
      dmem_read = 0; dmem_write = 0; dmem_resp = 0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1;
      cycle({tag, ".rst"});
      rst = 0;
      chk({tag, ".rst_stall_count"}, 32'(stall_count), 32'd0);
      chk({tag, ".rst_flush_count"}, 32'(flush_count), 32'd0);
   endtask

   // ---------------- table vectors (all start and end in RUN) ----------------
   typedef struct packed {
      rv32i_control_word id_v, ex_v, mem_v;
      logic redir, ir, irs, dr, dw, drs;
      logic [4:0] e_loads;
      logic e_flush, e_bubble;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mkv(input rv32i_control_word i, input rv32i_control_word e,
                                input rv32i_control_word m, input bit redir, input bit ir,
                                input bit irs, input bit dr, input bit dw, input bit drs,
                                input logic [4:0] l, input bit f, input bit b);
      vec_t v;
      v.id_v = i; v.ex_v = e; v.mem_v = m; v.redir = redir; v.ir = ir; v.irs = irs;
      v.dr = dr; v.dw = dw; v.drs = drs; v.e_loads = l; v.e_flush = f; v.e_bubble = b;
      return v;
   endfunction

   rv32i_control_word lw5, add6_5_1, sw5, lui_rs5, lw0, add0, beq3, add3, lui3, slt3_bren,
                      add6_3, lw3, slti7_3, jal_rs5, add3_norf, add_use3;

   initial begin
      NOP       = mk(op_imm, 0, 0, 0, 0, 0, alu_out);
      lw5       = mk(op_load, 2, 1, 0, 5, 1, lw);
      add6_5_1  = mk(op_reg, 0, 5, 1, 6, 1, alu_out);
      sw5       = mk(op_store, 2, 2, 5, 0, 0, alu_out);
      lui_rs5   = mk(op_lui, 0, 5, 5, 7, 1, u_imm);
      lw0       = mk(op_load, 2, 1, 0, 0, 1, lw);
      add0      = mk(op_reg, 0, 0, 0, 6, 1, alu_out);
      beq3      = mk(op_br, 0, 3, 0, 0, 0, alu_out);
      add3      = mk(op_reg, 0, 1, 2, 3, 1, alu_out);
      lui3      = mk(op_lui, 0, 0, 0, 3, 1, u_imm);
      slt3_bren = mk(op_reg, 2, 1, 2, 3, 1, br_en);
      add6_3    = mk(op_reg, 0, 3, 1, 6, 1, alu_out);
      lw3       = mk(op_load, 2, 1, 0, 3, 1, lw);
      slti7_3   = mk(op_imm, 2, 3, 0, 7, 1, alu_out);
      jal_rs5   = mk(op_jal, 0, 5, 5, 1, 1, pc_plus4);
      add3_norf = mk(op_reg, 0, 1, 2, 3, 0, alu_out);
      add_use3  = mk(op_reg, 0, 3, 0, 6, 1, alu_out);

      vecs[0]  = mkv(NOP, NOP, NOP,           0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[1]  = mkv(add6_5_1, lw5, NOP,      0, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[2]  = mkv(sw5, lw5, NOP,           0, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[3]  = mkv(lui_rs5, lw5, NOP,       0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[4]  = mkv(add0, lw0, NOP,          0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[5]  = mkv(beq3, add3, NOP,         0, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[6]  = mkv(beq3, lui3, NOP,         0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[7]  = mkv(beq3, slt3_bren, NOP,    0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[8]  = mkv(add6_3, add3, NOP,       0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[9]  = mkv(beq3, NOP, lw3,          0, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[10] = mkv(slti7_3, add3, NOP,      0, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[11] = mkv(NOP, NOP, NOP,           1, 1, 1, 0, 0, 0, 5'b11111, 1, 0);
      vecs[12] = mkv(add6_5_1, lw5, NOP,      1, 0, 0, 0, 0, 0, 5'b00111, 0, 1);
      vecs[13] = mkv(NOP, NOP, NOP,           1, 1, 0, 0, 0, 0, 5'b00000, 0, 0);
      vecs[14] = mkv(NOP, NOP, NOP,           0, 1, 1, 1, 0, 1, 5'b11111, 0, 0);
      vecs[15] = mkv(NOP, NOP, NOP,           0, 0, 0, 0, 1, 0, 5'b00000, 0, 0);
      vecs[16] = mkv(jal_rs5, lw5, NOP,       0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);
      vecs[17] = mkv(beq3, add3_norf, NOP,    0, 0, 0, 0, 0, 0, 5'b11111, 0, 0);

      held_i = 0; held_d = 0; m_stall = 0; m_flush = 0;
      rst = 1;
      idle_inputs();
      @(posedge clk);
      #1;

      // reset-state check
      do_reset("init");
      chk("init.reset_loads", 32'(got_loads), 32'd0);
      chk("init.reset_masks", 32'({got_imask, got_dmask}), 32'd0);

      // ---------------- table ----------------
      for (int v = 0; v < 18; v++) begin
         id_c = vecs[v].id_v; ex_c = vecs[v].ex_v; mem_c = vecs[v].mem_v;
         id_redirect = vecs[v].redir; imem_read = vecs[v].ir; imem_resp = vecs[v].irs;
         dmem_read = vecs[v].dr; dmem_write = vecs[v].dw; dmem_resp = vecs[v].drs;
         cycle($sformatf("vec%0d", v));
         chk($sformatf("vec%0d.tbl_loads", v),  32'(got_loads), 32'(vecs[v].e_loads));
         chk($sformatf("vec%0d.tbl_flush", v),  32'(got_flush), 32'(vecs[v].e_flush));
         chk($sformatf("vec%0d.tbl_bubble", v), 32'(got_bubble), 32'(vecs[v].e_bubble));
      end
      idle_inputs();

      // ---------------- load-use: one bubble ----------------
      do_reset("lu");
      id_c = add6_5_1; ex_c = lw5; mem_c = NOP;
      cycle("lu.c0");
      chk("lu.c0_loads", 32'(got_loads), 32'b00111);
      chk("lu.c0_bubble", 32'(got_bubble), 32'd1);
      ex_c = NOP; mem_c = lw5;
      cycle("lu.c1");
      chk("lu.c1_loads", 32'(got_loads), 32'b11111);
      chk("lu.stall_count", 32'(stall_count), 32'd1);

      // ---------------- beq after ALU op: one bubble ----------------
      do_reset("br_alu");
      id_c = beq3; ex_c = add3; mem_c = NOP;
      cycle("br_alu.c0");
      chk("br_alu.c0_bubble", 32'(got_bubble), 32'd1);
      ex_c = NOP; mem_c = add3;
      cycle("br_alu.c1");
      chk("br_alu.c1_loads", 32'(got_loads), 32'b11111);

      // ---------------- beq after load: two bubbles ----------------
      do_reset("br_ld");
      id_c = beq3; ex_c = lw3; mem_c = NOP;
      cycle("br_ld.c0");
      chk("br_ld.c0_bubble", 32'(got_bubble), 32'd1);
      ex_c = NOP; mem_c = lw3;
      cycle("br_ld.c1");
      chk("br_ld.c1_bubble", 32'(got_bubble), 32'd1);
      mem_c = NOP;
      cycle("br_ld.c2");
      chk("br_ld.c2_loads", 32'(got_loads), 32'b11111);
      chk("br_ld.stall_count", 32'(stall_count), 32'd2);

      // ---------------- split completion: I first, D three cycles later ----------------
      do_reset("split");
      id_c = NOP; ex_c = NOP; mem_c = NOP;
      imem_read = 1; dmem_read = 1; imem_resp = 1; dmem_resp = 0;
      cycle("split.c0");
      chk("split.c0_loads", 32'(got_loads), 32'd0);
      imem_resp = 0;
      cycle("split.c1");
      chk("split.c1_imask", 32'(got_imask), 32'd1);
      chk("split.c1_loads", 32'(got_loads), 32'd0);
      cycle("split.c2");
      dmem_resp = 1;
      cycle("split.c3");
      chk("split.c3_loads", 32'(got_loads), 32'b11111);
      chk("split.stall_count", 32'(stall_count), 32'd3);
      dmem_resp = 0; imem_read = 0; dmem_read = 0;
      cycle("split.c4");
      chk("split.c4_imask", 32'(got_imask), 32'd0);

      // ---------------- simultaneous responses ----------------
      do_reset("simul");
      imem_read = 1; dmem_read = 1; imem_resp = 1; dmem_resp = 1;
      cycle("simul.c0");
      chk("simul.c0_loads", 32'(got_loads), 32'b11111);
      imem_resp = 0; dmem_resp = 0; dmem_read = 0;
      cycle("simul.c1");
      chk("simul.c1_masks", 32'({got_imask, got_dmask}), 32'd0);
      chk("simul.c1_loads", 32'(got_loads), 32'd0);
      imem_read = 0;

      // ---------------- redirect under memory stall ----------------
      do_reset("redir");
      id_redirect = 1; dmem_read = 1; dmem_resp = 0;
      cycle("redir.c0");
      chk("redir.c0_flush", 32'(got_flush), 32'd0);
      chk("redir.c0_loads", 32'(got_loads), 32'd0);
      dmem_resp = 1;
      cycle("redir.c1");
      chk("redir.c1_flush", 32'(got_flush), 32'd1);
      chk("redir.c1_loads", 32'(got_loads), 32'b11111);
      chk("redir.flush_count", 32'(flush_count), 32'd1);
      idle_inputs();

      // ---------------- reset while in D_DONE ----------------
      do_reset("rstw");
      imem_read = 1; imem_resp = 0; dmem_read = 1; dmem_resp = 1;
      cycle("rstw.c0");
      dmem_resp = 0;
      cycle("rstw.c1");
      chk("rstw.c1_dmask", 32'(got_dmask), 32'd1);
      rst = 1; id_redirect = 1;
      cycle("rstw.c2");
      chk("rstw.c2_loads", 32'(got_loads), 32'd0);
      chk("rstw.c2_dmask", 32'(got_dmask), 32'd0);
      rst = 0;
      chk("rstw.stall_count", 32'(stall_count), 32'd0);
      chk("rstw.flush_count", 32'(flush_count), 32'd0);
      cycle("rstw.c3");
      chk("rstw.c3_dmask", 32'(got_dmask), 32'd0);
      chk("rstw.c3_loads", 32'(got_loads), 32'd0);
      idle_inputs();

      // ---------------- randomized run against the model ----------------
      do_reset("rnd");
      for (int n = 0; n < 600; n++) begin
         id_c = rnd_ctrl(); ex_c = rnd_ctrl(); mem_c = rnd_ctrl();
         id_redirect = ($urandom_range(0, 4) == 0);
         imem_read   = ($urandom_range(0, 9) < 7);
         imem_resp   = ($urandom_range(0, 9) < 4);
         dmem_read   = ($urandom_range(0, 9) < 3);
         dmem_write  = ($urandom_range(0, 9) < 2);
         dmem_resp   = ($urandom_range(0, 9) < 4);
         rst         = ($urandom_range(0, 49) == 0);
         cycle($sformatf("rnd%0d", n));
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic rv32i_control_word rnd_ctrl();
      rv32i_control_word c;
      rv32i_opcode op;
      case ($urandom_range(0, 9))
         0: op = op_lui;   1: op = op_auipc; 2: op = op_jal;  3: op = op_jalr;
         4: op = op_br;    5: op = op_load;  6: op = op_store; 7: op = op_imm;
         8: op = op_reg;   default: op = op_csr;
      endcase
      c = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             regfilemux_sel_t'($urandom_range(0, 4)));
      return c;
   endfunction

endmodule
